// File: rtl/alarm_clock_pkg.sv
// Shared types and sizing helpers for the alarm clock controller.
package alarm_clock_pkg;

    typedef enum logic [2:0] {
        ModeRun    = 3'd0,
        ModeSetHr  = 3'd1,
        ModeSetMin = 3'd2,
        ModeAlmHr  = 3'd3,
        ModeAlmMin = 3'd4
    } mode_e;

    typedef enum logic [1:0] {
        AlmIdle   = 2'd0,
        AlmRing   = 2'd1,
        AlmSnooze = 2'd2,
        AlmDone   = 2'd3
    } alm_e;

    localparam logic [1:0] DispMmSs  = 2'd0;
    localparam logic [1:0] DispTime  = 2'd1;
    localparam logic [1:0] DispAlarm = 2'd2;

    localparam int unsigned LedW = 10;

    localparam int unsigned DefRepeatDlyMs = 500;
    localparam int unsigned DefRepeatMs    = 150;
    localparam int unsigned DefTimeoutS    = 30;
    localparam int unsigned DefRingS       = 60;
    localparam int unsigned DefSnoozeS     = 300;

    // Counters run 0..N-1, so clog2(N) bits are enough.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned umax(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    localparam int unsigned MsCntW  = cnt_w(DefRepeatDlyMs);
    localparam int unsigned SecCntW = cnt_w(DefTimeoutS);
    localparam int unsigned SnzCntW = cnt_w(DefSnoozeS);

    function automatic mode_e next_mode(input mode_e m);
        unique case (m)
            ModeRun:    return ModeSetHr;
            ModeSetHr:  return ModeSetMin;
            ModeSetMin: return ModeAlmHr;
            ModeAlmHr:  return ModeAlmMin;
            default:    return ModeRun;
        endcase
    endfunction

endpackage

// File: rtl/alarm_clock_ctrl_if.sv
// Buttons, timebase ticks and datapath controls between the alarm clock FSM and its surroundings.
interface alarm_clock_ctrl_if;
    import alarm_clock_pkg::*;

    logic            tick_1ms;
    logic            tick_1s;
    logic            btn_mode;
    logic            btn_up;
    logic            btn_ok;
    logic            alarm_en;
    logic            alarm_match;
    logic            run_en;
    logic            inc_hr;
    logic            inc_min;
    logic            ainc_hr;
    logic            ainc_min;
    logic [1:0]      disp_sel;
    logic            blank_hi;
    logic            blank_lo;
    logic [LedW-1:0] ring_led;
    logic            ringing;

    modport master (
        output tick_1ms, tick_1s, btn_mode, btn_up, btn_ok, alarm_en, alarm_match,
        input  run_en, inc_hr, inc_min, ainc_hr, ainc_min, disp_sel, blank_hi, blank_lo,
               ring_led, ringing
    );

    modport slave (
        input  tick_1ms, tick_1s, btn_mode, btn_up, btn_ok, alarm_en, alarm_match,
        output run_en, inc_hr, inc_min, ainc_hr, ainc_min, disp_sel, blank_hi, blank_lo,
               ring_led, ringing
    );

endinterface

// File: rtl/btn_edge_sync.sv
// Two-flop synchroniser with a registered rising-edge pulse (raw edge to pulse: 3 cycles).
module btn_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic pulse
);

    logic s1_q, s2_q, s3_q, pulse_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            s3_q    <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            s1_q    <= raw;
            s2_q    <= s1_q;
            s3_q    <= s2_q;
            pulse_q <= s2_q & ~s3_q;
        end
    end

    assign level = s2_q;
    assign pulse = pulse_q;

endmodule

// File: rtl/alarm_clock_ctrl.sv
// Mode/set sequencing, increment strobes with auto-repeat, blink and alarm ring/snooze control.
module alarm_clock_ctrl
    import alarm_clock_pkg::*;
#(
    parameter int unsigned REPEAT_DLY_MS = DefRepeatDlyMs,
    parameter int unsigned REPEAT_MS     = DefRepeatMs,
    parameter int unsigned TIMEOUT_S     = DefTimeoutS,
    parameter int unsigned RING_S        = DefRingS,
    parameter int unsigned SNOOZE_S      = DefSnoozeS
) (
    input logic              clk,
    input logic              rst,
    alarm_clock_ctrl_if.slave bus
);

    localparam int unsigned MsW  = umax(MsCntW, cnt_w(umax(REPEAT_DLY_MS, REPEAT_MS)));
    localparam int unsigned SecW = umax(SecCntW, cnt_w(TIMEOUT_S));
    localparam int unsigned AlmW = umax(SnzCntW, cnt_w(umax(RING_S, SNOOZE_S)));

    logic p_mode, p_up, p_ok, up_lvl, mode_lvl, ok_lvl;

    btn_edge_sync u_sync_mode (.clk(clk), .rst(rst), .raw(bus.btn_mode), .level(mode_lvl),
                               .pulse(p_mode));
    btn_edge_sync u_sync_up   (.clk(clk), .rst(rst), .raw(bus.btn_up), .level(up_lvl),
                               .pulse(p_up));
    btn_edge_sync u_sync_ok   (.clk(clk), .rst(rst), .raw(bus.btn_ok), .level(ok_lvl),
                               .pulse(p_ok));

    logic unused_lvl;
    assign unused_lvl = mode_lvl ^ ok_lvl;

    mode_e           mode_q, mode_d;
    alm_e            alm_q, alm_d;
    logic [SecW-1:0] idle_q, idle_d;
    logic [MsW-1:0]  hold_q, hold_d;
    logic [AlmW-1:0] acnt_q, acnt_d;
    logic            rep_q, rep_d, rep_fire;
    logic            phase_q;
    logic [LedW-1:0] led_q, led_d;
    logic            inc_hr_q, inc_min_q, ainc_hr_q, ainc_min_q;
    logic            inc_hr_d, inc_min_d, ainc_hr_d, ainc_min_d;

    // Presses that end a ring belong to the alarm and are hidden from the mode FSM.
    logic ring_now, pm, pu, po, set_state, up_evt, blink;
    assign ring_now  = (alm_q == AlmRing);
    assign pm        = p_mode & ~ring_now;
    assign pu        = p_up & ~ring_now;
    assign po        = p_ok & ~ring_now;
    assign set_state = (mode_q != ModeRun);

    always_comb begin
        mode_d = mode_q;
        idle_d = idle_q;
        if (!set_state || pm || pu || po) begin
            idle_d = '0;
        end else if (bus.tick_1s) begin
            if (idle_q == SecW'(TIMEOUT_S - 1)) begin
                idle_d = '0;
                mode_d = ModeRun;
            end else begin
                idle_d = idle_q + 1'b1;
            end
        end
        if (po && set_state) begin
            mode_d = ModeRun;
        end else if (pm) begin
            mode_d = next_mode(mode_q);
        end
    end

    always_comb begin
        hold_d   = hold_q;
        rep_d    = rep_q;
        rep_fire = 1'b0;
        if (!up_lvl) begin
            hold_d = '0;
            rep_d  = 1'b0;
        end else if (bus.tick_1ms) begin
            if (hold_q == (rep_q ? MsW'(REPEAT_MS - 1) : MsW'(REPEAT_DLY_MS - 1))) begin
                hold_d   = '0;
                rep_d    = 1'b1;
                rep_fire = 1'b1;
            end else begin
                hold_d = hold_q + 1'b1;
            end
        end
    end

    assign up_evt     = pu | rep_fire;
    assign inc_hr_d   = up_evt & (mode_q == ModeSetHr);
    assign inc_min_d  = up_evt & (mode_q == ModeSetMin);
    assign ainc_hr_d  = up_evt & (mode_q == ModeAlmHr);
    assign ainc_min_d = up_evt & (mode_q == ModeAlmMin);

    always_comb begin
        alm_d  = alm_q;
        acnt_d = acnt_q;
        led_d  = '0;
        if (!bus.alarm_en) begin
            alm_d  = AlmIdle;
            acnt_d = '0;
        end else begin
            unique case (alm_q)
                AlmIdle: begin
                    // A match seen while setting is parked in Done so it cannot ring late.
                    if (bus.alarm_match) begin
                        alm_d  = (mode_q == ModeRun) ? AlmRing : AlmDone;
                        acnt_d = '0;
                    end
                end
                AlmRing: begin
                    led_d = led_q;
                    if (p_ok) begin
                        alm_d  = AlmSnooze;
                        acnt_d = '0;
                        led_d  = '0;
                    end else if (p_mode || p_up) begin
                        alm_d = AlmDone;
                        led_d = '0;
                    end else if (bus.tick_1s) begin
                        if (acnt_q == AlmW'(RING_S - 1)) begin
                            alm_d  = AlmDone;
                            acnt_d = '0;
                            led_d  = '0;
                        end else begin
                            acnt_d = acnt_q + 1'b1;
                            led_d  = ~led_q;
                        end
                    end
                end
                AlmSnooze: begin
                    if (bus.tick_1s) begin
                        if (acnt_q == AlmW'(SNOOZE_S - 1)) begin
                            alm_d  = AlmRing;
                            acnt_d = '0;
                        end else begin
                            acnt_d = acnt_q + 1'b1;
                        end
                    end
                end
                AlmDone: begin
                    if (!bus.alarm_match) alm_d = AlmIdle;
                end
                default: alm_d = AlmIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q     <= ModeRun;
            alm_q      <= AlmIdle;
            idle_q     <= '0;
            hold_q     <= '0;
            acnt_q     <= '0;
            rep_q      <= 1'b0;
            phase_q    <= 1'b0;
            led_q      <= '0;
            inc_hr_q   <= 1'b0;
            inc_min_q  <= 1'b0;
            ainc_hr_q  <= 1'b0;
            ainc_min_q <= 1'b0;
        end else begin
            mode_q     <= mode_d;
            alm_q      <= alm_d;
            idle_q     <= idle_d;
            hold_q     <= hold_d;
            acnt_q     <= acnt_d;
            rep_q      <= rep_d;
            phase_q    <= phase_q ^ bus.tick_1s;
            led_q      <= led_d;
            inc_hr_q   <= inc_hr_d;
            inc_min_q  <= inc_min_d;
            ainc_hr_q  <= ainc_hr_d;
            ainc_min_q <= ainc_min_d;
        end
    end

    // Blink is suppressed while auto-repeating so the changing digits stay readable.
    assign blink = phase_q & ~rep_q;

    always_comb begin
        bus.disp_sel = DispMmSs;
        bus.run_en   = 1'b1;
        bus.blank_hi = 1'b0;
        bus.blank_lo = 1'b0;
        unique case (mode_q)
            ModeSetHr: begin
                bus.disp_sel = DispTime;
                bus.run_en   = 1'b0;
                bus.blank_hi = blink;
            end
            ModeSetMin: begin
                bus.disp_sel = DispTime;
                bus.run_en   = 1'b0;
                bus.blank_lo = blink;
            end
            ModeAlmHr: begin
                bus.disp_sel = DispAlarm;
                bus.blank_hi = blink;
            end
            ModeAlmMin: begin
                bus.disp_sel = DispAlarm;
                bus.blank_lo = blink;
            end
            default: ;
        endcase
    end

    assign bus.inc_hr   = inc_hr_q;
    assign bus.inc_min  = inc_min_q;
    assign bus.ainc_hr  = ainc_hr_q;
    assign bus.ainc_min = ainc_min_q;
    assign bus.ring_led = led_q;
    assign bus.ringing  = ring_now;

endmodule

// File: tb/tb_alarm_clock_ctrl.sv
// Directed bench for alarm_clock_ctrl; increment strobes are scored against a queue of expected ms.
module tb_alarm_clock_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;

    alarm_clock_ctrl_if bus ();

    alarm_clock_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    int ms_cnt = 0;
    int n_inc_hr = 0, n_inc_min = 0, n_ainc_hr = 0, n_ainc_min = 0;
    bit sb_on = 1'b0;
    int exp_ms[$];
    logic [9:0] exp_led;
    int base_min, base_all;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input int which);
        case (which)
            0: bus.btn_mode = 1'b1;
            1: bus.btn_up   = 1'b1;
            default: bus.btn_ok = 1'b1;
        endcase
        step(6);
        bus.btn_mode = 1'b0;
        bus.btn_up   = 1'b0;
        bus.btn_ok   = 1'b0;
        step(4);
    endtask

    task automatic tick_s();
        bus.tick_1s = 1'b1;
        step(1);
        bus.tick_1s = 1'b0;
        step(1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.tick_1ms = 1'b0; bus.tick_1s = 1'b0;
        bus.btn_mode = 1'b0; bus.btn_up = 1'b0; bus.btn_ok = 1'b0;
        bus.alarm_en = 1'b0; bus.alarm_match = 1'b0;
        step(3);
        rst = 1'b0;
        step(1);
    endtask

    function automatic int all_strobes();
        return n_inc_hr + n_inc_min + n_ainc_hr + n_ainc_min;
    endfunction

    // Scoreboard side: each inc_min strobe must match the next expected ms timestamp.
    always @(negedge clk) begin
        if (bus.inc_hr)   n_inc_hr++;
        if (bus.ainc_hr)  n_ainc_hr++;
        if (bus.ainc_min) n_ainc_min++;
        if (bus.inc_min) begin
            n_inc_min++;
            if (sb_on) begin
                check("sb_pending", 32'(exp_ms.size() > 0), 32'd1);
                if (exp_ms.size() > 0) check("sb_inc_min_ms", ms_cnt, exp_ms.pop_front());
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: reset values and mode cycling
        do_reset();
        check("rst_run_en", bus.run_en, 1);
        check("rst_disp", bus.disp_sel, 0);
        check("rst_blank", {bus.blank_hi, bus.blank_lo}, 0);
        check("rst_led", bus.ring_led, 0);
        check("rst_ringing", bus.ringing, 0);
        check("rst_strobes", {bus.inc_hr, bus.inc_min, bus.ainc_hr, bus.ainc_min}, 0);
        press(0);
        check("m1_disp", bus.disp_sel, 1);
        check("m1_run_en", bus.run_en, 0);
        press(0);
        check("m2_disp", bus.disp_sel, 1);
        check("m2_run_en", bus.run_en, 0);
        press(0);
        check("m3_disp", bus.disp_sel, 2);
        check("m3_run_en", bus.run_en, 1);
        press(0);
        press(0);
        check("m5_disp", bus.disp_sel, 0);
        check("m5_run_en", bus.run_en, 1);
        check("m_no_strobes", all_strobes(), 0);

        // 2: SET_MIN, btn_up held ~900 ms: strobes at press+4, 500, 650, 800 ms
        do_reset();
        press(0);
        press(0);
        step(2);
        base_all = all_strobes();
        sb_on = 1'b1;
        ms_cnt = 0;
        exp_ms.push_back(0);
        bus.btn_up = 1'b1;
        step(3);
        check("up_early", bus.inc_min, 0);
        step(1);
        check("up_press4", bus.inc_min, 1);
        exp_ms.push_back(500);
        exp_ms.push_back(650);
        exp_ms.push_back(800);
        step(2);
        for (int i = 0; i < 900; i++) begin
            bus.tick_1ms = 1'b1;
            ms_cnt++;
            step(1);
            bus.tick_1ms = 1'b0;
            step(3);
        end
        bus.btn_up = 1'b0;
        step(6);
        for (int i = 0; i < 200; i++) begin
            bus.tick_1ms = 1'b1;
            ms_cnt++;
            step(1);
            bus.tick_1ms = 1'b0;
            step(1);
        end
        step(4);
        sb_on = 1'b0;
        check("sb_drained", exp_ms.size(), 0);
        check("rep_total", all_strobes() - base_all, 4);

        // 3: SET_HR idle timeout after 30 s, blink on hour pair
        do_reset();
        press(0);
        base_all = all_strobes();
        tick_s();
        check("blink_hi", bus.blank_hi, 1);
        check("blink_lo", bus.blank_lo, 0);
        for (int i = 1; i < 29; i++) tick_s();
        check("to_29_disp", bus.disp_sel, 1);
        check("to_29_run_en", bus.run_en, 0);
        tick_s();
        check("to_30_disp", bus.disp_sel, 0);
        check("to_30_run_en", bus.run_en, 1);
        step(2);
        check("to_no_strobes", all_strobes() - base_all, 0);

        // 4: ring in RUN, LED toggling, p_up dismisses, re-arm after match drops
        do_reset();
        bus.alarm_en = 1'b1;
        step(1);
        bus.alarm_match = 1'b1;
        step(2);
        check("ring_on", bus.ringing, 1);
        check("ring_led0", bus.ring_led, 0);
        exp_led = 10'h000;
        for (int i = 0; i < 4; i++) begin
            tick_s();
            exp_led = ~exp_led;
            check("ring_led_tog", bus.ring_led, exp_led);
        end
        base_all = all_strobes();
        press(1);
        check("up_dismiss", bus.ringing, 0);
        check("up_dismiss_led", bus.ring_led, 0);
        check("up_dismiss_disp", bus.disp_sel, 0);
        check("up_dismiss_strb", all_strobes() - base_all, 0);
        step(5);
        check("done_holds", bus.ringing, 0);
        bus.alarm_match = 1'b0;
        step(2);
        bus.alarm_match = 1'b1;
        step(2);
        check("rearm_ring", bus.ringing, 1);

        // 5: snooze 300 s then ring again, 60 s ring limit
        do_reset();
        bus.alarm_en = 1'b1;
        bus.alarm_match = 1'b1;
        step(2);
        tick_s();
        press(2);
        check("snz_off", bus.ringing, 0);
        check("snz_led", bus.ring_led, 0);
        for (int i = 0; i < 299; i++) tick_s();
        check("snz_299", bus.ringing, 0);
        tick_s();
        check("snz_300", bus.ringing, 1);
        check("snz_led_rst", bus.ring_led, 0);
        for (int i = 0; i < 59; i++) tick_s();
        check("ring_59", bus.ringing, 1);
        check("ring_59_led", bus.ring_led, 10'h3FF);
        tick_s();
        check("ring_60", bus.ringing, 0);
        check("ring_60_led", bus.ring_led, 0);

        // 6: p_mode dismiss is consumed; alarm_en drop; reset in SET_MIN with btn_up held
        do_reset();
        bus.alarm_en = 1'b1;
        bus.alarm_match = 1'b1;
        step(2);
        press(0);
        check("mode_dismiss", bus.ringing, 0);
        check("mode_consumed", bus.disp_sel, 0);
        bus.alarm_match = 1'b0;
        step(2);
        bus.alarm_match = 1'b1;
        step(2);
        tick_s();
        check("en_pre_led", bus.ring_led, 10'h3FF);
        bus.alarm_en = 1'b0;
        step(1);
        check("en_drop_ring", bus.ringing, 0);
        check("en_drop_led", bus.ring_led, 0);
        do_reset();
        press(0);
        press(0);
        base_min = n_inc_min;
        bus.btn_up = 1'b1;
        step(2);
        rst = 1'b1;
        step(3);
        rst = 1'b0;
        step(10);
        check("rst_mid_disp", bus.disp_sel, 0);
        check("rst_mid_run_en", bus.run_en, 1);
        check("rst_mid_no_inc", n_inc_min - base_min, 0);
        bus.btn_up = 1'b0;

        // 7: match rising while setting must not ring until the next match
        do_reset();
        bus.alarm_en = 1'b1;
        press(0);
        bus.alarm_match = 1'b1;
        step(3);
        press(2);
        step(2);
        check("set_match_disp", bus.disp_sel, 0);
        check("set_match_quiet", bus.ringing, 0);
        bus.alarm_match = 1'b0;
        step(2);
        bus.alarm_match = 1'b1;
        step(2);
        check("next_match_ring", bus.ringing, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
